aes_bist_ctrl: RTL and testbench

Parametrised built-in self-test controller for the iterative AES cores. It replaces the reset-triggered, single-vector, fixed-direction LED checker with a start-triggered sequencer. The sequencer drives any AES-128/256 core through a start/done handshake in encrypt or decrypt mode and runs one vector or sweeps all of them. It reads vectors from an external synchronous ROM, enforces a per-vector timeout, and reports pass/fail counts and latched LED verdicts for the FPGA top level.

---
 rtl/aes_bist_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aes_bist_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bist_ctrl.sv
// aes_bist_ctrl: start-triggered BIST sequencer for iterative AES-128/256 cores.
// Vectors come from a synchronous ROM; each runs through a start/done handshake with a timeout.
module aes_bist_ctrl #(
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned KEY_W   = 128,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sweep,
    input  logic [ADDR_W-1:0] sel,
    input  logic              mode,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [KEY_W-1:0]  vec_key,
    input  logic [127:0]      vec_pt,
    input  logic [127:0]      vec_ct,
    output logic              core_start,
    output logic              core_mode,
    output logic [KEY_W-1:0]  core_key,
    output logic [127:0]      core_din,
    input  logic              core_done,
    input  logic [127:0]      core_dout,
    output logic              busy,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              timeout_flag,
    output logic              led_success,
    output logic              led_fail
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        LAUNCH,
        WAIT,
        CHECK,
        NEXT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic              start_d;
    logic              start_rise_c;
    logic              run_go_c;
    logic              sel_ok_c;
    logic              timed_out_c;
    logic              bad_sel;
    logic [ADDR_W-1:0] last_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [127:0]      expected;
    logic [127:0]      result;

    // Out-of-range sel is only possible when the ROM does not fill the address space.
    if (NUM_VEC == (32'd1 << ADDR_W)) begin : g_sel_full
        assign sel_ok_c = 1'b1;
    end else begin : g_sel_part
        assign sel_ok_c = (32'(sel) < NUM_VEC);
    end

    assign start_rise_c = start & ~start_d;
    assign run_go_c     = start_rise_c & ((state == IDLE) | (state == DONE));
    assign timed_out_c  = (to_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; done beats a timeout expiring in the same cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (run_go_c) begin
                    next_state = (sweep | sel_ok_c) ? FETCH : DONE;
                end
            end
            FETCH:  next_state = LOAD;
            LOAD:   next_state = LAUNCH;
            LAUNCH: next_state = WAIT;
            WAIT: begin
                if (core_done) begin
                    next_state = CHECK;
                end else if (timed_out_c) begin
                    next_state = NEXT;
                end
            end
            CHECK:  next_state = NEXT;
            NEXT:   next_state = (vec_addr == last_idx) ? DONE : FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Datapath, counters and latched verdicts; vec_addr doubles as the vector index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d      <= 1'b1;
            vec_addr     <= '0;
            last_idx     <= '0;
            core_start   <= 1'b0;
            core_mode    <= 1'b0;
            core_key     <= '0;
            core_din     <= '0;
            expected     <= '0;
            result       <= '0;
            to_cnt       <= '0;
            busy         <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_flag <= 1'b0;
            led_success  <= 1'b0;
            led_fail     <= 1'b0;
            bad_sel      <= 1'b0;
        end else begin
            start_d    <= start;
            core_start <= (next_state == LAUNCH);
            case (state)
                IDLE, DONE: begin
                    if (run_go_c) begin
                        core_mode    <= mode;
                        vec_addr     <= sweep ? '0 : sel;
                        last_idx     <= sweep ? IDX_LAST : sel;
                        pass_cnt     <= '0;
                        fail_cnt     <= '0;
                        timeout_flag <= 1'b0;
                        led_success  <= 1'b0;
                        led_fail     <= 1'b0;
                        bad_sel      <= ~(sweep | sel_ok_c);
                        busy         <= sweep | sel_ok_c;
                    end else if (state == DONE) begin
                        busy        <= 1'b0;
                        led_success <= (fail_cnt == '0) & ~bad_sel;
                        led_fail    <= (fail_cnt != '0) | bad_sel;
                    end
                end
                LOAD: begin
                    core_key <= vec_key;
                    core_din <= core_mode ? vec_ct : vec_pt;
                    expected <= core_mode ? vec_pt : vec_ct;
                end
                LAUNCH: begin
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        result <= core_dout;
                    end else if (timed_out_c) begin
                        fail_cnt     <= fail_cnt + CNT_W'(1);
                        timeout_flag <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    if (result == expected) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    if (vec_addr != last_idx) begin
                        vec_addr <= vec_addr + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// tb_aes_bist_ctrl: directed checks of the BIST sequencer on an AES-128/8-vector instance
// and an AES-256/4-vector instance, each driving a table-lookup core model.
module tb_aes_bist_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       sweep   = 1'b0;
    logic       mode    = 1'b0;
    logic [2:0] sel_a   = '0;
    logic [1:0] sel_b   = '0;

    localparam logic [127:0] KEY_A [8] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h0, 128'h0};
    localparam logic [127:0] PT_A [8] = '{
        128'h00112233445566778899aabbccddeeff, 128'h3243f6a8885a308d313198a2e0370734,
        128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710,
        128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    localparam logic [127:0] CT_A [8] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h3925841d02dc09fbdc118597196a0b32,
        128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
        128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'hf795bd4a52e29ed713d313fa20e398a9};
    localparam logic [255:0] KEY_B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT_B [4] = '{
        128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    localparam logic [127:0] CT_B [4] = '{
        128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h591ccb10d410ed26dc5ba74a31362870,
        128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h23304b7a39f9f3ff067d8d8f5e24ecc7};

    logic [2:0]   vec_addr_a;
    logic [127:0] vec_key_a, vec_pt_a, vec_ct_a;
    logic         core_start_a, core_mode_a, core_done_a;
    logic [127:0] core_key_a, core_din_a, core_dout_a;
    logic         busy_a, tflag_a, led_ok_a, led_bad_a;
    logic [3:0]   pass_a, fail_a;

    logic [1:0]   vec_addr_b;
    logic [255:0] vec_key_b, core_key_b;
    logic [127:0] vec_pt_b, vec_ct_b, core_din_b, core_dout_b;
    logic         core_start_b, core_mode_b, core_done_b;
    logic         busy_b, tflag_b, led_ok_b, led_bad_b;
    logic [2:0]   pass_b, fail_b;

    aes_bist_ctrl #(.NUM_VEC(8), .ADDR_W(3), .KEY_W(128), .TIMEOUT(200)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sweep(sweep), .sel(sel_a), .mode(mode),
        .vec_addr(vec_addr_a), .vec_key(vec_key_a), .vec_pt(vec_pt_a), .vec_ct(vec_ct_a),
        .core_start(core_start_a), .core_mode(core_mode_a), .core_key(core_key_a),
        .core_din(core_din_a), .core_done(core_done_a), .core_dout(core_dout_a),
        .busy(busy_a), .pass_cnt(pass_a), .fail_cnt(fail_a), .timeout_flag(tflag_a),
        .led_success(led_ok_a), .led_fail(led_bad_a));

    aes_bist_ctrl #(.NUM_VEC(4), .ADDR_W(2), .KEY_W(256), .TIMEOUT(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sweep(sweep), .sel(sel_b), .mode(mode),
        .vec_addr(vec_addr_b), .vec_key(vec_key_b), .vec_pt(vec_pt_b), .vec_ct(vec_ct_b),
        .core_start(core_start_b), .core_mode(core_mode_b), .core_key(core_key_b),
        .core_din(core_din_b), .core_done(core_done_b), .core_dout(core_dout_b),
        .busy(busy_b), .pass_cnt(pass_b), .fail_cnt(fail_b), .timeout_flag(tflag_b),
        .led_success(led_ok_b), .led_fail(led_bad_b));

    // Synchronous ROMs; corrupt_idx flips bit 0 of one ciphertext in ROM A
    int corrupt_idx = -1;
    always @(posedge clk) begin
        vec_key_a <= KEY_A[vec_addr_a];
        vec_pt_a  <= PT_A[vec_addr_a];
        vec_ct_a  <= CT_A[vec_addr_a] ^ ((int'(vec_addr_a) == corrupt_idx) ? 128'h1 : 128'h0);
        vec_key_b <= KEY_B;
        vec_pt_b  <= PT_B[vec_addr_b];
        vec_ct_b  <= CT_B[vec_addr_b];
    end

    function automatic logic [127:0] model_a(input logic [127:0] key, input logic [127:0] din,
                                             input logic dec);
        for (int i = 0; i < 8; i++) begin
            if (key == KEY_A[i] && !dec && din == PT_A[i]) return CT_A[i];
            if (key == KEY_A[i] && dec && din == CT_A[i]) return PT_A[i];
        end
        return ~din;
    endfunction

    function automatic logic [127:0] model_b(input logic [255:0] key, input logic [127:0] din,
                                             input logic dec);
        for (int i = 0; i < 4; i++) begin
            if (key == KEY_B && !dec && din == PT_B[i]) return CT_B[i];
            if (key == KEY_B && dec && din == CT_B[i]) return PT_B[i];
        end
        return ~din;
    endfunction

    // Core models: done is high in the cycle lat-1 cycles after the core_start cycle
    int   lat_a  = 11;
    int   hang_a = -1;
    int   lat_b  = 15;
    int   cnt_a, cnt_b;
    logic run_a, run_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_a <= 1'b0; cnt_a <= 0; core_dout_a <= '0;
        end else if (core_start_a) begin
            run_a       <= (hang_a != int'(vec_addr_a));
            cnt_a       <= 1;
            core_dout_a <= model_a(core_key_a, core_din_a, core_mode_a);
        end else if (run_a) begin
            cnt_a <= cnt_a + 1;
            if (cnt_a == lat_a - 1) run_a <= 1'b0;
        end
    end
    assign core_done_a = run_a && (cnt_a == lat_a - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_b <= 1'b0; cnt_b <= 0; core_dout_b <= '0;
        end else if (core_start_b) begin
            run_b       <= 1'b1;
            cnt_b       <= 1;
            core_dout_b <= model_b(core_key_b, core_din_b, core_mode_b);
        end else if (run_b) begin
            cnt_b <= cnt_b + 1;
            if (cnt_b == lat_b - 1) run_b <= 1'b0;
        end
    end
    assign core_done_b = run_b && (cnt_b == lat_b - 1);

    // Launch log: cycle stamp and address of every core_start
    int cyc = 0;
    int n_launch_a = 0;
    int n_launch_b = 0;
    int launch_cyc [256];
    int launch_addr [256];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_start_a) begin
            launch_cyc[n_launch_a]  <= cyc;
            launch_addr[n_launch_a] <= int'(vec_addr_a);
            n_launch_a <= n_launch_a + 1;
        end
        if (core_start_b) n_launch_b <= n_launch_b + 1;
    end

    bit   cur_b = 1'b0;
    logic busy_m, core_start_m, led_m;
    assign busy_m       = cur_b ? busy_b : busy_a;
    assign core_start_m = cur_b ? core_start_b : core_start_a;
    assign led_m        = cur_b ? (led_ok_b | led_bad_b) : (led_ok_a | led_bad_a);

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One start pulse, then wait (bounded) for busy to fall; optional mid-run start pulse
    task automatic run_dut(input bit use_b, input int max_cyc, input int pulse_at,
                           input int watch_addr, output int first_k, output bit prev_led,
                           output bit addr_ok);
        int k;
        cur_b = use_b;
        @(posedge clk); #1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        first_k  = -1;
        prev_led = 1'b0;
        addr_ok  = 1'b1;
        k = 0;
        while (k < max_cyc) begin
            @(posedge clk); #1;
            k++;
            if (k == 1 || k == pulse_at + 1) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (k == pulse_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            if (core_start_m && first_k < 0) first_k = k;
            if (watch_addr >= 0 && int'(vec_addr_a) != watch_addr) addr_ok = 1'b0;
            if (!busy_m) break;
            prev_led = led_m;
        end
        check("busy_fall", 256'(busy_m), 256'(0));
    endtask

    int base, first_k, k;
    bit prev_led, addr_ok;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 256'(busy_a), 256'(0));
        check("rst_leds", 256'({led_ok_a, led_bad_a}), 256'(0));
        check("rst_counts", 256'({pass_a, fail_a, tflag_a}), 256'(0));
        check("rst_addr", 256'(vec_addr_a), 256'(0));
        check("rst_core", 256'({core_start_a, core_mode_a, core_key_a, core_din_a}), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encrypt sweep, all 8 vectors pass at 15-cycle launch spacing
        sweep = 1'b1; mode = 1'b0; base = n_launch_a;
        run_dut(1'b0, 400, -1, -1, first_k, prev_led, addr_ok);
        check("enc_first_launch", 256'(first_k), 256'(3));
        check("enc_launches", 256'(n_launch_a - base), 256'(8));
        for (int i = 1; i < 8; i++) begin
            check("enc_spacing", 256'(launch_cyc[base+i] - launch_cyc[base+i-1]), 256'(15));
            check("enc_launch_addr", 256'(launch_addr[base+i]), 256'(i));
        end
        check("enc_pass", 256'(pass_a), 256'(8));
        check("enc_fail", 256'(fail_a), 256'(0));
        check("enc_led_before_fall", 256'(prev_led), 256'(0));
        check("enc_leds", 256'({led_ok_a, led_bad_a}), 256'(2'b10));

        // Decrypt vector 5 with a corrupted ciphertext
        sweep = 1'b0; mode = 1'b1; sel_a = 3'd5; corrupt_idx = 5; base = n_launch_a;
        run_dut(1'b0, 200, -1, 5, first_k, prev_led, addr_ok);
        corrupt_idx = -1;
        check("dec_launches", 256'(n_launch_a - base), 256'(1));
        check("dec_addr_stable", 256'(addr_ok), 256'(1));
        check("dec_counts", 256'({pass_a, fail_a}), 256'({4'd0, 4'd1}));
        check("dec_tflag", 256'(tflag_a), 256'(0));
        check("dec_leds", 256'({led_ok_a, led_bad_a}), 256'(2'b01));
        check("dec_mode", 256'(core_mode_a), 256'(1));
        check("dec_din", 256'(core_din_a), 256'(CT_A[5] ^ 128'h1));

        // Vector 2 hangs; it times out 200 cycles after launch and vector 3 still runs
        sweep = 1'b1; mode = 1'b0; hang_a = 2; base = n_launch_a;
        run_dut(1'b0, 1000, -1, -1, first_k, prev_led, addr_ok);
        hang_a = -1;
        check("to_launches", 256'(n_launch_a - base), 256'(8));
        check("to_gap", 256'(launch_cyc[base+3] - launch_cyc[base+2]), 256'(204));
        check("to_v3_addr", 256'(launch_addr[base+3]), 256'(3));
        check("to_counts", 256'({pass_a, fail_a}), 256'({4'd7, 4'd1}));
        check("to_tflag", 256'(tflag_a), 256'(1));
        check("to_leds", 256'({led_ok_a, led_bad_a}), 256'(2'b01));

        // Done coincides with timeout expiry; a mid-run start pulse is ignored
        sweep = 1'b0; sel_a = 3'd0; lat_a = 201; base = n_launch_a;
        run_dut(1'b0, 500, 50, -1, first_k, prev_led, addr_ok);
        lat_a = 11;
        check("edge_launches", 256'(n_launch_a - base), 256'(1));
        check("edge_counts", 256'({pass_a, fail_a}), 256'({4'd1, 4'd0}));
        check("edge_tflag", 256'(tflag_a), 256'(0));
        check("edge_leds", 256'({led_ok_a, led_bad_a}), 256'(2'b10));

        // Reset during WAIT of vector 4, start held high across reset
        sweep = 1'b1; base = n_launch_a; cur_b = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1;
        k = 0;
        while (n_launch_a < base + 5 && k < 500) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) start_a = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        check("mid_pass", 256'(pass_a), 256'(4));
        check("mid_addr", 256'(vec_addr_a), 256'(4));
        check("mid_busy", 256'(busy_a), 256'(1));
        rst_n = 1'b0; start_a = 1'b1;
        #1;
        check("abort_busy", 256'(busy_a), 256'(0));
        check("abort_counts", 256'({pass_a, fail_a, tflag_a}), 256'(0));
        check("abort_addr", 256'(vec_addr_a), 256'(0));
        check("abort_core", 256'({core_start_a, core_key_a, core_din_a}), 256'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("held_start_busy", 256'(busy_a), 256'(0));
        check("held_start_launches", 256'(n_launch_a - base), 256'(5));
        start_a = 1'b0;
        @(posedge clk); #1;
        base = n_launch_a;
        run_dut(1'b0, 400, -1, -1, first_k, prev_led, addr_ok);
        check("rerun_first_launch", 256'(first_k), 256'(3));
        check("rerun_pass", 256'(pass_a), 256'(8));
        check("rerun_launches", 256'(n_launch_a - base), 256'(8));

        // AES-256 instance: sweep of 4, then single decrypt of vector 3
        sweep = 1'b1; mode = 1'b0; base = n_launch_b;
        run_dut(1'b1, 400, -1, -1, first_k, prev_led, addr_ok);
        check("b_first_launch", 256'(first_k), 256'(3));
        check("b_launches", 256'(n_launch_b - base), 256'(4));
        check("b_counts", 256'({pass_b, fail_b, tflag_b}), 256'({3'd4, 3'd0, 1'b0}));
        check("b_leds", 256'({led_ok_b, led_bad_b}), 256'(2'b10));
        sweep = 1'b0; mode = 1'b1; sel_b = 2'd3; base = n_launch_b;
        run_dut(1'b1, 200, -1, -1, first_k, prev_led, addr_ok);
        check("b_single_launches", 256'(n_launch_b - base), 256'(1));
        check("b_single_counts", 256'({pass_b, fail_b}), 256'({3'd1, 3'd0}));
        check("b_single_addr", 256'(vec_addr_b), 256'(3));
        check("b_single_key", core_key_b, KEY_B);
        check("b_single_din", 256'(core_din_b), 256'(CT_B[3]));
        check("b_single_leds", 256'({led_ok_b, led_bad_b}), 256'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
